// File: rtl/pe_seq_ctrl.sv
// Mat-vec pass sequencer for PE_core: clears accumulators, streams k_len SRAM reads, flags done.
// Optional macro PE_SEQ_PERF_EN adds the perf_cycles busy-cycle counter port.
module pe_seq_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned K_MAX     = 64,
  parameter int unsigned CNT_W     = 9,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  k_len,
  input  logic [ADDR_W-1:0] base_w,
  input  logic [ADDR_W-1:0] base_v,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_raddr_w,
  output logic [ADDR_W-1:0] sram_raddr_v,
  output logic              pe_clr,
  output logic              alu_start,
  output logic [CNT_W-1:0]  cycle_num,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int unsigned DW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned CW1 = CNT_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic [DW-1:0]     drain_cnt;
  logic [CNT_W-1:0]  k_reg;
  logic [ADDR_W-1:0] bw_reg;
  logic [ADDR_W-1:0] bv_reg;

  logic             req;
  logic             k_ok;
  logic             last;
  logic [CNT_W:0]   idx_p2;

  // Abort masks start even in IDLE, so neither accept nor err fires.
  assign req    = start && !abort;
  assign k_ok   = (k_len != '0) && (k_len <= CNT_W'(K_MAX));
  assign last   = (idx == k_reg - CNT_W'(1));
  assign idx_p2 = {1'b0, idx} + CW1'(2);

  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= S_IDLE;
      idx          <= '0;
      drain_cnt    <= '0;
      k_reg        <= '0;
      bw_reg       <= '0;
      bv_reg       <= '0;
      sram_ren     <= 1'b0;
      sram_raddr_w <= '0;
      sram_raddr_v <= '0;
      pe_clr       <= 1'b0;
      alu_start    <= 1'b0;
      cycle_num    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      pe_clr    <= 1'b0;
      alu_start <= 1'b0;
      cycle_num <= '0;
      sram_ren  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      if (abort && state != S_IDLE) begin
        state        <= S_IDLE;
        busy         <= 1'b0;
        idx          <= '0;
        drain_cnt    <= '0;
        sram_raddr_w <= '0;
        sram_raddr_v <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req && k_ok) begin
              state        <= S_CLEAR;
              k_reg        <= k_len;
              bw_reg       <= base_w;
              bv_reg       <= base_v;
              busy         <= 1'b1;
              pe_clr       <= 1'b1;
              sram_ren     <= 1'b1;
              sram_raddr_w <= base_w;
              sram_raddr_v <= base_v;
            end else if (req) begin
              err <= 1'b1;
            end
          end
          S_CLEAR: begin
            state     <= S_RUN;
            idx       <= '0;
            alu_start <= 1'b1;
            if (k_reg > CNT_W'(1)) begin
              sram_ren     <= 1'b1;
              sram_raddr_w <= bw_reg + ADDR_W'(1);
              sram_raddr_v <= bv_reg + ADDR_W'(1);
            end
          end
          // Read for element idx+1 is issued alongside MAC for element idx.
          S_RUN: begin
            if (last) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              idx       <= idx + CNT_W'(1);
              alu_start <= 1'b1;
              cycle_num <= idx + CNT_W'(1);
              if (idx_p2 < {1'b0, k_reg}) begin
                sram_ren     <= 1'b1;
                sram_raddr_w <= bw_reg + ADDR_W'(idx_p2);
                sram_raddr_v <= bv_reg + ADDR_W'(idx_p2);
              end
            end
          end
          S_DRAIN: begin
            if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PE_SEQ_PERF_EN
  // Saturating count of busy cycles for the most recent pass.
  always_ff @(posedge clk) begin
    if (srst) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE && req && k_ok) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
